// File: rtl/program_counter_pkg.sv
// Shared definitions for the program counter: per-cycle operation codes and
// the default return-stack depth.
package program_counter_pkg;

  // One decoded operation per clock edge.
  typedef enum logic [2:0] {
    PC_OP_HOLD = 3'd0,
    PC_OP_INC  = 3'd1,
    PC_OP_JUMP = 3'd2,
    PC_OP_CALL = 3'd3,
    PC_OP_RET  = 3'd4,
    PC_OP_ERR  = 3'd5
  } pc_op_e;

  localparam int unsigned STACK_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/program_counter_return_stack.sv
// Return-address LIFO. The top entry is read asynchronously. The empty and
// full flags are registered alongside the stack pointer. Push and pop are
// never asserted together by the caller.
module return_stack
  import program_counter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  logic [SP_W-1:0]       sp;
  logic [SP_W-1:0]       sp_next;
  logic [IDX_W-1:0]      top_idx;
  logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];

  // Next stack pointer; guarded so the pointer never wraps.
  always_comb begin
    sp_next = sp;
    if (push && !full) begin
      sp_next = sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp_next = sp - SP_W'(1);
    end
  end

  // Pointer and flags, registered together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp    <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      sp    <= sp_next;
      empty <= (sp_next == '0);
      full  <= (sp_next == SP_W'(STACK_DEPTH));
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[sp[IDX_W-1:0]] <= din;
    end
  end

  // Asynchronous read of the top entry.
  always_comb begin
    top_idx = IDX_W'(sp - SP_W'(1));
    dout    = mem[top_idx];
  end

endmodule

// File: rtl/program_counter.sv
// Program counter with hardware return-address stack. Decodes the command
// inputs to one operation per edge, then updates pc, the stack and the
// sticky fault flag.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH   = 8,
  parameter int unsigned          STACK_DEPTH  = STACK_DEPTH_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  jump,
  input  logic                  call,
  input  logic                  ret,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  fault
);

  pc_op_e                op;
  logic [ADDR_WIDTH-1:0] pc_plus_one;
  logic [ADDR_WIDTH-1:0] stack_top;

  assign pc_plus_one = pc_out + ADDR_WIDTH'(1);

  // Priority decode of the command inputs.
  always_comb begin
    op = PC_OP_HOLD;
    if (!enable) begin
      op = PC_OP_HOLD;
    end else if (call && ret) begin
      op = PC_OP_ERR;
    end else if (ret) begin
      op = stack_empty ? PC_OP_ERR : PC_OP_RET;
    end else if (call) begin
      op = stack_full ? PC_OP_ERR : PC_OP_CALL;
    end else if (jump) begin
      op = PC_OP_JUMP;
    end else begin
      op = PC_OP_INC;
    end
  end

  return_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_return_stack (
    .clock(clock),
    .reset(reset),
    .push (op == PC_OP_CALL),
    .pop  (op == PC_OP_RET),
    .din  (pc_plus_one),
    .dout (stack_top),
    .empty(stack_empty),
    .full (stack_full)
  );

  // PC register and sticky fault flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_out <= RESET_VECTOR;
      fault  <= 1'b0;
    end else begin
      unique case (op)
        PC_OP_INC:  pc_out <= pc_plus_one;
        PC_OP_JUMP: pc_out <= jump_addr;
        PC_OP_CALL: pc_out <= jump_addr;
        PC_OP_RET:  pc_out <= stack_top;
        default:    pc_out <= pc_out;
      endcase
      if (op == PC_OP_ERR) begin
        fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: a queue-based reference model
// produces the expected state after each edge; a monitor compares on the
// falling edge (or right after an asynchronous reset).
module tb_program_counter;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    int unsigned pc;
    bit          empty;
    bit          full;
    bit          fault;
    string       tag;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          jump = 1'b0;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic [AW-1:0] pc_out;
  logic          stack_empty;
  logic          stack_full;
  logic          fault;
  logic          probe = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned m_pc;
  int unsigned m_stack[$];
  bit          m_fault;
  exp_t        exp_q[$];
  string       cur_tag = "reset";

  program_counter #(
    .ADDR_WIDTH  (AW),
    .STACK_DEPTH (DEPTH),
    .RESET_VECTOR(8'h00)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .jump       (jump),
    .call       (call),
    .ret        (ret),
    .jump_addr  (jump_addr),
    .pc_out     (pc_out),
    .stack_empty(stack_empty),
    .stack_full (stack_full),
    .fault      (fault)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    m_pc = 0;
    m_stack.delete();
    m_fault = 1'b0;
  endfunction

  function automatic void model_step(bit en, bit j, bit c, bit r, int unsigned a);
    if (!en) return;
    if (c && r) m_fault = 1'b1;
    else if (r) begin
      if (m_stack.size() == 0) m_fault = 1'b1;
      else m_pc = m_stack.pop_back();
    end else if (c) begin
      if (m_stack.size() == DEPTH) m_fault = 1'b1;
      else begin
        m_stack.push_back((m_pc + 1) % 256);
        m_pc = a;
      end
    end else if (j) m_pc = a;
    else m_pc = (m_pc + 1) % 256;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.pc    = m_pc;
    e.empty = (m_stack.size() == 0);
    e.full  = (m_stack.size() == DEPTH);
    e.fault = m_fault;
    e.tag   = cur_tag;
    exp_q.push_back(e);
  endfunction

  function automatic void check(string name, int unsigned got, int unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endfunction

  // Monitor: pops one expectation per falling edge or explicit probe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock or posedge probe);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".pc"},    pc_out,      e.pc);
        check({e.tag, ".empty"}, stack_empty, e.empty);
        check({e.tag, ".full"},  stack_full,  e.full);
        check({e.tag, ".fault"}, fault,       e.fault);
      end
    end
  end

  task automatic cycle(input bit en, input bit j, input bit c, input bit r, input int unsigned a);
    enable = en; jump = j; call = c; ret = r; jump_addr = AW'(a);
    @(posedge clock);
    model_step(en, j, c, r, a);
    push_exp();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
  endtask

  // Reset asserted between edges; state must clear before the next edge.
  task automatic async_reset();
    @(negedge clock);
    #1 reset = 1'b1;
    model_reset();
    #1 push_exp();
    probe = 1'b1;
    #1 probe = 1'b0;
    enable = 0; jump = 0; call = 0; ret = 0;
    @(posedge clock);
    push_exp();
    #1 reset = 1'b0;
  endtask

  initial begin
    int r;
    model_reset();
    @(posedge clock);
    push_exp();
    #1 reset = 1'b0;

    cur_tag = "t1_count";
    idle(3);
    cur_tag = "t1_stall";
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 8'h55);

    cur_tag = "t2_wrap";
    cycle(1, 1, 0, 0, 8'hFE);
    idle(2);

    cur_tag = "t3_nest";
    cycle(1, 1, 0, 0, 8'h10);
    cycle(1, 0, 1, 0, 8'h40);
    idle(1);
    cycle(1, 0, 1, 0, 8'h80);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);

    cur_tag = "t4_full";
    cycle(1, 0, 1, 0, 8'h20);
    cycle(1, 0, 1, 0, 8'h30);
    cycle(1, 0, 1, 0, 8'hA0);
    cycle(1, 0, 1, 0, 8'hFF);
    cycle(1, 0, 1, 0, 8'h77);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, 0);

    cur_tag = "t5_fault";
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 1, 1, 8'h99);
    cycle(1, 1, 1, 1, 8'h99);
    idle(2);

    cur_tag = "t6_areset";
    cycle(1, 0, 1, 0, 8'h60);
    cycle(1, 0, 1, 0, 8'h70);
    async_reset();
    idle(2);

    cur_tag = "rand";
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      if (r < 2) async_reset();
      else if (r < 16) cycle(0, $urandom_range(0, 1), $urandom_range(0, 1),
                             $urandom_range(0, 1), $urandom_range(0, 255));
      else if (r < 56) cycle(1, $urandom_range(0, 1), 1, 0, $urandom_range(0, 255));
      else if (r < 96) cycle(1, $urandom_range(0, 1), 0, 1, $urandom_range(0, 255));
      else if (r < 102) cycle(1, $urandom_range(0, 1), 1, 1, $urandom_range(0, 255));
      else if (r < 132) cycle(1, 1, 0, 0, $urandom_range(0, 255));
      else cycle(1, 0, 0, 0, $urandom_range(0, 255));
    end

    enable = 0; jump = 0; call = 0; ret = 0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
